// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive IO block: receiver FSM states,
// IO port decode constants and status byte bit positions.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rxState_t;

  localparam logic [7:0] DATA_PORT   = 8'h01;
  localparam logic [7:0] STATUS_PORT = 8'h03;

  localparam int unsigned ST_READY   = 0;
  localparam int unsigned ST_OVERRUN = 1;
  localparam int unsigned ST_FRAMING = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, wrapping pointers, occupancy counter.
// A pop on an empty FIFO is ignored; a push while full only lands with a pop.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver with a byte FIFO, exposed to a Z80-style IO bus as a
// data port (FIFO head) and a status port (flags), both read-only.
module uart_rx_io
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic [7:0] Address,
  inout  wire  [7:0] Data,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  output logic       rx_ready
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  // Line synchronizer and start-edge detection
  logic       rxMeta;
  logic       rxSync;
  logic       rxPrev;
  logic [2:0] warm;
  logic       startEdge;

  // The sync flops reset high, so edges are ignored until rxPrev holds a
  // genuine line sample; a line already low at release cannot start a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
      warm   <= '0;
    end else begin
      rxMeta <= uart_rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      warm   <= {warm[1:0], 1'b1};
    end
  end

  assign startEdge = warm[2] && rxPrev && !rxSync;

  // Oversampling tick generator
  logic [DIV_W-1:0] divCnt;
  logic             tick;
  logic             leaveIdle;

  assign tick = (divCnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt <= '0;
    end else if (leaveIdle || tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  // Receiver FSM
  rxState_t   state;
  rxState_t   stateNext;
  logic [3:0] tickCnt;
  logic [3:0] tickNext;
  logic [2:0] bitIdx;
  logic [2:0] bitNext;
  logic [7:0] shiftReg;
  logic [7:0] shiftNext;
  logic       pushByte;
  logic       setFraming;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      tickCnt  <= tickNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
    end
  end

  always_comb begin
    stateNext  = state;
    tickNext   = tickCnt;
    bitNext    = bitIdx;
    shiftNext  = shiftReg;
    leaveIdle  = 1'b0;
    pushByte   = 1'b0;
    setFraming = 1'b0;
    case (state)
      IDLE: begin
        if (startEdge) begin
          stateNext = START;
          tickNext  = '0;
          leaveIdle = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (tickCnt == 4'd7) begin
            tickNext  = '0;
            bitNext   = '0;
            stateNext = rxSync ? IDLE : DATA;
          end else begin
            tickNext = tickCnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tickNext = tickCnt + 4'd1;
          if (tickCnt == 4'd15) begin
            shiftNext = {rxSync, shiftReg[7:1]};
            bitNext   = bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
              stateNext = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          tickNext = tickCnt + 4'd1;
          if (tickCnt == 4'd15) begin
            stateNext  = IDLE;
            pushByte   = rxSync;
            setFraming = !rxSync;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus decode: side effects fire once, when a decoded read strobe ends
  logic       rdStrobe;
  logic       dataSel;
  logic       statSel;
  logic       dataSelQ;
  logic       statSelQ;
  logic       dataEnd;
  logic       statEnd;
  logic [7:0] fifoDout;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       overrun;
  logic       framingErr;
  logic [7:0] statusByte;
  logic [7:0] rdData;

  assign rdStrobe = IORQ && RD && !WR;
  assign dataSel  = rdStrobe && (Address == DATA_PORT);
  assign statSel  = rdStrobe && (Address == STATUS_PORT);
  assign dataEnd  = dataSelQ && !dataSel;
  assign statEnd  = statSelQ && !statSel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataSelQ <= 1'b0;
      statSelQ <= 1'b0;
    end else begin
      dataSelQ <= dataSel;
      statSelQ <= statSel;
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) fifo (
    .clk  (clk),
    .reset(reset),
    .push (pushByte),
    .pop  (dataEnd),
    .din  (shiftReg),
    .dout (fifoDout),
    .empty(fifoEmpty),
    .full (fifoFull)
  );

  assign rx_ready = !fifoEmpty;

  // A full FIFO popped in the same cycle still accepts the byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun    <= 1'b0;
      framingErr <= 1'b0;
    end else begin
      if (pushByte && fifoFull && !dataEnd) begin
        overrun <= 1'b1;
      end else if (statEnd) begin
        overrun <= 1'b0;
      end
      if (setFraming) begin
        framingErr <= 1'b1;
      end else if (statEnd) begin
        framingErr <= 1'b0;
      end
    end
  end

  always_comb begin
    statusByte             = '0;
    statusByte[ST_READY]   = rx_ready;
    statusByte[ST_OVERRUN] = overrun;
    statusByte[ST_FRAMING] = framingErr;
  end

  assign rdData = statSel ? statusByte : (fifoEmpty ? 8'h00 : fifoDout);
  assign Data   = (dataSel || statSel) ? rdData : 'z;

endmodule
